rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter.sv | 137 +++++++++++++
 tb/tb_rom_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// Two-port arbiter in front of a line-oriented ROM. Port 0 (fetch) and
// port 1 (load) compete for single outstanding ROM transactions; ties are
// broken round-robin and a stalled ROM is answered with an error response.
module rom_arbiter #(
  parameter int TIMEOUT = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [14:0]  req0_addr,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [14:0]  req1_addr,
  output logic         req1_ready,
  output logic [1:0]   resp_valid,
  output logic [511:0] resp_data,
  output logic         resp_err,
  output logic         rom_cs,
  output logic         rom_addr_valid,
  output logic [14:0]  rom_addr,
  input  logic         rom_data_ready,
  input  logic [511:0] rom_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t       state;
  state_t       state_nxt;
  logic         last_grant;
  logic         grant;
  logic         pick;
  logic [8:0]   line_idx;
  logic [7:0]   wait_cnt;
  logic         err_flag;
  logic         timeout_hit;
  logic [511:0] data_q;
  logic         unused_addr_bits;

  // Byte offsets inside a line never reach the ROM.
  assign unused_addr_bits = ^{req0_addr[5:0], req1_addr[5:0]};

  // Port 1 wins when it is alone, or on a tie when port 0 was served last.
  assign pick = req1_valid && (!req0_valid || !last_grant);

  // The cycle that would be the TIMEOUT-th stalled ISSUE cycle ends the wait.
  assign timeout_hit = !rom_data_ready && (wait_cnt == LAST_WAIT);

  // Next-state and output decode; reset forces every output low.
  always_comb begin
    state_nxt      = state;
    req0_ready     = 1'b0;
    req1_ready     = 1'b0;
    rom_cs         = 1'b0;
    rom_addr_valid = 1'b0;
    rom_addr       = '0;
    resp_valid     = 2'b00;
    resp_err       = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          state_nxt  = ISSUE;
          req0_ready = !pick;
          req1_ready = pick;
        end
      end
      ISSUE: begin
        rom_cs         = 1'b1;
        rom_addr_valid = 1'b1;
        rom_addr       = {line_idx, 6'b0};
        if (rom_data_ready || timeout_hit) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = grant ? 2'b10 : 2'b01;
        resp_err   = err_flag;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      state_nxt      = IDLE;
      req0_ready     = 1'b0;
      req1_ready     = 1'b0;
      rom_cs         = 1'b0;
      rom_addr_valid = 1'b0;
      rom_addr       = '0;
      resp_valid     = 2'b00;
      resp_err       = 1'b0;
    end
  end

  assign resp_data = rst ? '0 : data_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Grant bookkeeping, wait counter and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      grant      <= 1'b0;
      line_idx   <= '0;
      wait_cnt   <= '0;
      err_flag   <= 1'b0;
      data_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            grant      <= pick;
            last_grant <= pick;
            line_idx   <= pick ? req1_addr[14:6] : req0_addr[14:6];
            wait_cnt   <= '0;
          end
        end
        ISSUE: begin
          if (rom_data_ready) begin
            data_q   <= rom_data;
            err_flag <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (timeout_hit) begin
              data_q   <= '0;
              err_flag <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: a transaction-level model checks every output on
// every cycle, while directed sequences pin literal expectations.
module tb_rom_arbiter;

  localparam int TIMEOUT = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid;
  logic [14:0]  req0_addr;
  logic         req0_ready;
  logic         req1_valid;
  logic [14:0]  req1_addr;
  logic         req1_ready;
  logic [1:0]   resp_valid;
  logic [511:0] resp_data;
  logic         resp_err;
  logic         rom_cs;
  logic         rom_addr_valid;
  logic [14:0]  rom_addr;
  logic         rom_data_ready;
  logic [511:0] rom_data;
  logic [31:0]  salt;

  int checks   = 0;
  int failures = 0;

  rom_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .rom_cs(rom_cs), .rom_addr_valid(rom_addr_valid), .rom_addr(rom_addr),
    .rom_data_ready(rom_data_ready), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] pat(input logic [8:0] idx, input logic [31:0] s);
    logic [31:0] w;
    w = 32'hC0DE_0000 | {23'd0, idx};
    return {16{w}} ^ {16{s}};
  endfunction

  // ROM contents are a function of the line index, perturbed by salt.
  always_comb rom_data = pat(rom_addr[14:6], salt);

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  logic         model_on = 1'b0;
  logic         m_busy = 1'b0, m_answered = 1'b0, m_port = 1'b0, m_last = 1'b1, m_err = 1'b0;
  logic [8:0]   m_line = '0;
  int           m_issues = 0;
  logic [511:0] m_data = '0;
  logic         e_r0, e_r1, e_cs, e_av, e_err, g;
  logic [14:0]  e_addr;
  logic [1:0]   e_rv;
  logic [511:0] e_data;

  always @(negedge clk) begin
    if (rst) model_on = 1'b1;
    if (model_on) begin
      e_r0 = 0; e_r1 = 0; e_cs = 0; e_av = 0; e_addr = '0; e_rv = 2'b00; e_err = 0;
      if (rst) begin
        e_data = '0;
        m_busy = 0; m_answered = 0; m_last = 1; m_err = 0; m_data = '0;
      end else begin
        e_data = m_data;
        if (!m_busy) begin
          if (req0_valid || req1_valid) begin
            g = (req0_valid && req1_valid) ? !m_last : req1_valid;
            e_r0 = !g; e_r1 = g;
            m_busy = 1; m_answered = 0; m_issues = 0;
            m_port = g; m_last = g;
            m_line = g ? req1_addr[14:6] : req0_addr[14:6];
          end
        end else if (!m_answered) begin
          e_cs = 1; e_av = 1; e_addr = {m_line, 6'b0};
          m_issues++;
          if (rom_data_ready) begin
            m_answered = 1; m_err = 0; m_data = rom_data;
          end else if (m_issues == TIMEOUT) begin
            m_answered = 1; m_err = 1; m_data = '0;
          end
        end else begin
          e_rv = m_port ? 2'b10 : 2'b01;
          e_err = m_err;
          m_busy = 0;
        end
      end
      chk("m_req0_ready", req0_ready, e_r0);
      chk("m_req1_ready", req1_ready, e_r1);
      chk("m_rom_cs", rom_cs, e_cs);
      chk("m_rom_addr_valid", rom_addr_valid, e_av);
      chk("m_rom_addr", rom_addr, e_addr);
      chk("m_resp_valid", resp_valid, e_rv);
      chk("m_resp_err", resp_err, e_err);
      chk("m_resp_data", resp_data, e_data);
    end
  end

  // ---------------- stimulus and literal expectations ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input int n);
    req0_valid = 0; req1_valid = 0; rom_data_ready = 1;
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [511:0] lit;
  int  n;
  logic seen;
  logic slow;

  initial begin
    rst = 1; req0_valid = 0; req1_valid = 0; req0_addr = '0; req1_addr = '0;
    rom_data_ready = 0; salt = '0;
    tick(); #5;
    chk("reset_rom_cs", rom_cs, 0);
    chk("reset_resp_valid", resp_valid, 0);
    chk("reset_resp_data", resp_data, 0);
    tick(); rst = 0;

    // Port 0 alone at 0x1234, ROM answers at once.
    req0_valid = 1; req0_addr = 15'h1234; rom_data_ready = 1;
    #5 chk("d1_req0_ready", req0_ready, 1);
    chk("d1_req1_ready", req1_ready, 0);
    tick(); req0_valid = 0;
    #5 chk("d1_rom_addr", rom_addr, 15'h1200);
    chk("d1_rom_cs", rom_cs, 1);
    tick();
    #5 chk("d1_resp_valid", resp_valid, 2'b01);
    lit = {16{32'hC0DE_0048}};
    chk("d1_resp_data", resp_data, lit);
    chk("d1_resp_err", resp_err, 0);
    tick(); #5 chk("d1_data_hold", resp_data, lit);
    chk("d1_valid_drop", resp_valid, 0);

    // Both ports request continuously after reset: 0,1,0,1 every 3 cycles.
    tick(); rst = 1;
    tick(); rst = 0;
    req0_valid = 1; req1_valid = 1; req0_addr = 15'h0100; req1_addr = 15'h7fc0;
    for (int k = 0; k < 12; k++) begin
      #5;
      chk("d2_req0_ready", req0_ready, (k % 6) == 0);
      chk("d2_req1_ready", req1_ready, (k % 6) == 3);
      chk("d2_resp_valid", resp_valid, ((k % 6) == 2) ? 2'b01 : (((k % 6) == 5) ? 2'b10 : 2'b00));
      tick();
    end
    quiet(2);

    // ROM never ready: TIMEOUT ISSUE cycles, then an error response.
    req0_valid = 1; req0_addr = 15'h0abc; rom_data_ready = 0;
    #5 chk("d3_grant", req0_ready, 1);
    tick(); req0_valid = 0;
    n = 0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (i > 0) tick();
      #5;
      if (rom_cs) n++;
      if (resp_valid != 0) begin
        seen = 1;
        chk("d3_issue_cycles", n, 8);
        chk("d3_resp_valid", resp_valid, 2'b01);
        chk("d3_resp_err", resp_err, 1);
        chk("d3_resp_data", resp_data, 0);
      end
    end
    chk("d3_resp_seen", seen, 1);
    tick();
    quiet(1);

    // ROM ready arrives on the 8th ISSUE cycle: normal response.
    req0_valid = 1; req0_addr = 15'h0055; rom_data_ready = 0;
    #5 chk("d4_grant", req0_ready, 1);
    tick(); req0_valid = 0;
    for (int i = 1; i <= 8; i++) begin
      rom_data_ready = (i == 8);
      #5 chk("d4_rom_cs", rom_cs, 1);
      tick();
    end
    rom_data_ready = 1;
    #5 chk("d4_resp_valid", resp_valid, 2'b01);
    chk("d4_resp_err", resp_err, 0);
    lit = {16{32'hC0DE_0001}};
    chk("d4_resp_data", resp_data, lit);
    quiet(2);

    // Reset during ISSUE aborts; port 0 then wins the tie.
    req0_valid = 1; req0_addr = 15'h0200; rom_data_ready = 0;
    tick(); req0_valid = 0; rst = 1;
    #5 chk("d5_cs_in_rst", rom_cs, 0);
    chk("d5_rv_in_rst", resp_valid, 0);
    tick(); rst = 0; req0_valid = 1; req1_valid = 1;
    #5 chk("d5_cs_after", rom_cs, 0);
    chk("d5_rv_after", resp_valid, 0);
    chk("d5_tie_req0", req0_ready, 1);
    chk("d5_tie_req1", req1_ready, 0);
    tick();
    quiet(3);

    // Port 1 pulses only while port 0 is in ISSUE: never granted.
    req0_valid = 1; req0_addr = 15'h0300; rom_data_ready = 0;
    tick(); req0_valid = 0; req1_valid = 1; req1_addr = 15'h0400;
    #5 chk("d6_r1_issue", req1_ready, 0);
    tick(); req1_valid = 0; rom_data_ready = 1;
    #5 chk("d6_r1_issue2", req1_ready, 0);
    tick();
    #5 chk("d6_resp_port0", resp_valid, 2'b01);
    tick();
    #5 chk("d6_r1_idle", req1_ready, 0);
    chk("d6_cs_idle", rom_cs, 0);

    // Randomized traffic with occasional stalls, timeouts and resets.
    slow = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (c % 150 == 0) slow = ($urandom_range(0, 2) == 0);
      rst        = ($urandom_range(0, 99) == 0);
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_addr  = 15'($urandom);
      req1_addr  = 15'($urandom);
      rom_data_ready = slow ? ($urandom_range(0, 14) == 0) : ($urandom_range(0, 1) == 1);
      salt = $urandom;
    end
    tick(); rst = 0;
    quiet(4);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
